odometer_scan_out: RTL

//  Readout stage directly downstream of the odometer parallel latch. On a capture

---
 rtl/odometer_scan_out.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/odometer_scan_out.sv
// odometer_scan_out
//   Readout stage behind the odometer parallel latch. A rising edge on
//   CAPTURE_REQ takes a stability-checked snapshot of PARALLEL_IN. The
//   snapshot is then shifted out MSB first as a framed word on SCAN_OUT,
//   one bit per CLK while SCAN_EN is high.
//   Frame layout: {1'b1, data[WIDTH-1:0], SAT, UNSTABLE, PAR}.
//
// Ports
//   CLK          in   readout clock, rising edge
//   RESETB       in   asynchronous active-low reset
//   PARALLEL_IN  in   latched count, asynchronous to CLK
//   CAPTURE_REQ  in   asynchronous level request; a rising edge starts a frame
//   SCAN_EN      in   shift enable
//   SCAN_OUT     out  serial frame bit; 0 outside SHIFT
//   BUSY         out  high in LOAD/SHIFT/DONE
//   FRAME_DONE   out  one-cycle pulse in DONE
//   MISS_CNT     out  requests dropped while busy, saturating at 15
module odometer_scan_out #(
  parameter int WIDTH     = 12,
  parameter int MAX_RETRY = 3
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic [WIDTH-1:0] PARALLEL_IN,
  input  logic             CAPTURE_REQ,
  input  logic             SCAN_EN,
  output logic             SCAN_OUT,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic [3:0]       MISS_CNT
);

  localparam int FRAME_LEN = WIDTH + 4;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_req_s1;
  logic                 r_req_s2;
  logic                 r_req_s3;
  logic                 r_load_first;
  logic [WIDTH-1:0]     r_snap_a;
  logic [RETRY_W-1:0]   r_retry;
  logic [FRAME_LEN-1:0] r_shreg;
  logic [CNT_W-1:0]     r_bitcnt;
  logic [3:0]           r_miss;

  logic                 w_start;
  logic                 w_load_exit;
  logic                 w_unstable;
  logic                 w_sat;
  logic                 w_par;
  logic [FRAME_LEN-1:0] w_frame;

  // Two flops resolve metastability; the third provides the edge reference.
  assign w_start = r_req_s2 & ~r_req_s3;

  // The sample taken in the current LOAD cycle goes straight into the
  // shift register on exit. It is therefore not held in a separate snapshot.
  assign w_sat   = &PARALLEL_IN;
  assign w_par   = ^{PARALLEL_IN, w_sat, w_unstable};
  assign w_frame = {1'b1, PARALLEL_IN, w_sat, w_unstable, w_par};

  always_comb begin
    w_state_next = r_state;
    w_load_exit  = 1'b0;
    w_unstable   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (!r_load_first) begin
          if (PARALLEL_IN == r_snap_a) begin
            w_load_exit = 1'b1;
          end else if (r_retry == RETRY_W'(MAX_RETRY)) begin
            // Retries used up: keep the latest sample and flag it.
            w_load_exit = 1'b1;
            w_unstable  = 1'b1;
          end
        end
        if (w_load_exit) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (SCAN_EN && (r_bitcnt == CNT_W'(FRAME_LEN - 1))) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
      r_req_s3 <= 1'b0;
    end else begin
      r_req_s1 <= CAPTURE_REQ;
      r_req_s2 <= r_req_s1;
      r_req_s3 <= r_req_s2;
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_load_first <= 1'b0;
      r_snap_a     <= '0;
      r_retry      <= '0;
      r_shreg      <= '0;
      r_bitcnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_load_first <= 1'b1;
            r_retry      <= '0;
          end
        end
        S_LOAD: begin
          r_load_first <= 1'b0;
          if (r_load_first) begin
            r_snap_a <= PARALLEL_IN;
          end else if (w_load_exit) begin
            r_shreg  <= w_frame;
            r_bitcnt <= '0;
          end else begin
            r_snap_a <= PARALLEL_IN;
            r_retry  <= r_retry + RETRY_W'(1);
          end
        end
        S_SHIFT: begin
          if (SCAN_EN) begin
            r_shreg  <= {r_shreg[FRAME_LEN-2:0], 1'b0};
            r_bitcnt <= r_bitcnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Any start seen outside IDLE, including the DONE cycle, is dropped and counted.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_miss <= 4'd0;
    end else if (w_start && (r_state != S_IDLE) && (r_miss != 4'hF)) begin
      r_miss <= r_miss + 4'd1;
    end
  end

  assign SCAN_OUT   = (r_state == S_SHIFT) & r_shreg[FRAME_LEN-1];
  assign BUSY       = (r_state != S_IDLE);
  assign FRAME_DONE = (r_state == S_DONE);
  assign MISS_CNT   = r_miss;

endmodule
